// File: rtl/uart_pkg.sv
// Shared types, parity-mode constants and parity helper for the UART transceiver.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Widest payload supported; narrower words are zero-extended, which leaves parity unchanged.
    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        TxIdle, TxStart, TxData, TxParity, TxStop
    } tx_state_t;

    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
    } rx_state_t;

    // Parity bit is present only for even/odd; the reserved mode behaves as none.
    function automatic logic par_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit to send (or expect) for a payload under the given mode.
    function automatic logic par_bit(input logic [MAX_DATA_BITS-1:0] data,
                                     input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_NONE: p = 1'b0;
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~(^data);
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator shared by the TX and RX paths.
module uart_baud_tick #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    // Divisor copy reloaded only at wrap so a live change never strands the counter past it.
    logic [DIV_WIDTH-1:0] div_q, div_d;

    assign tick = (cnt_q == div_q);

    // Count 0..div, wrap and pick up the new divisor on the tick.
    always_comb begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        div_d = div_q;
        if (tick) begin
            cnt_d = '0;
            div_d = baud_div;
        end
    end

    // Counter and divisor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= baud_div;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_xcvr_p.sv
// Full-duplex UART transceiver: runtime parity, 1/2 stop bits, oversampled RX with error flags.
module uart_xcvr_p #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    import uart_pkg::*;

    localparam int unsigned   CW         = $clog2(OVERSAMPLE + 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);
    // Start bit counts one extra tick: the first tick after accept is the bit boundary.
    localparam logic [CW-1:0] START_LAST = CW'(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);

    logic tick;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .tick     (tick)
    );

    // ---------------- TX ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d;
    logic                 tx_two_q, tx_two_d, tx_stop2_q, tx_stop2_d;
    logic                 txd_q, txd_d, tx_ready_q;

    assign txd      = txd_q;
    assign tx_ready = tx_ready_q;

    // TX next-state: walk start, data, optional parity and stop bits, OVERSAMPLE ticks each.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_par_en_d = tx_par_en_q;
        tx_two_d    = tx_two_q;
        tx_stop2_d  = tx_stop2_q;
        txd_d       = txd_q;
        unique case (tx_state_q)
            TxIdle: begin
                txd_d = 1'b1;
                if (tx_valid && tx_ready_q) begin
                    tx_state_d  = TxStart;
                    tx_cnt_d    = '0;
                    tx_bit_d    = '0;
                    tx_shift_d  = tx_data;
                    tx_par_d    = par_bit(MAX_DATA_BITS'(tx_data), parity_mode);
                    tx_par_en_d = par_en(parity_mode);
                    tx_two_d    = two_stop;
                    tx_stop2_d  = 1'b0;
                end
            end
            TxStart: if (tick) begin
                txd_d = 1'b0;
                if (tx_cnt_q == START_LAST) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = '0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxData: if (tick) begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_state_d = tx_par_en_q ? TxParity : TxStop;
                        txd_d      = tx_par_en_q ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxParity: if (tick) begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxStop;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TxStop: if (tick) begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_two_q && !tx_stop2_q) tx_stop2_d = 1'b1;
                    else                         tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // TX state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_par_en_q <= 1'b0;
            tx_two_q    <= 1'b0;
            tx_stop2_q  <= 1'b0;
            txd_q       <= 1'b1;
            tx_ready_q  <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_par_en_q <= tx_par_en_d;
            tx_two_q    <= tx_two_d;
            tx_stop2_q  <= tx_stop2_d;
            txd_q       <= txd_d;
            tx_ready_q  <= (tx_state_d == TxIdle);
        end
    end

    // ---------------- RX ----------------
    logic                 rxd_m, rxd_s;
    rx_state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [1:0]           rx_mode_q, rx_mode_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

    // RX next-state: validate start at mid-bit, then sample each bit centre.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_mode_d  = rx_mode_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        unique case (rx_state_q)
            RxIdle: if (tick && !rxd_s) begin
                rx_state_d = RxStart;
                rx_cnt_d   = '0;
                rx_mode_d  = parity_mode;
            end
            RxStart: if (tick) begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxData: if (tick) begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) rx_state_d = par_en(rx_mode_q) ? RxParity : RxStop;
                    else                       rx_bit_d   = rx_bit_q + 4'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxParity: if (tick) begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rxd_s;
                    rx_state_d = RxStop;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxStop: if (tick) begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    rx_perr_d  = par_en(rx_mode_q) &&
                                 (rx_par_q != par_bit(MAX_DATA_BITS'(rx_shift_q), rx_mode_q));
                    rx_ferr_d  = !rxd_s;
                    // A low stop bit may be a break: hold off until the line idles high.
                    rx_state_d = rxd_s ? RxIdle : RxWaitHigh;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RxWaitHigh: if (rxd_s) rx_state_d = RxIdle;
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX synchroniser, state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_mode_q  <= PAR_NONE;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rxd_m      <= rxd;
            rxd_s      <= rxd_m;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_mode_q  <= rx_mode_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

endmodule
